// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Parallel-to-serial front end. Accepts WIDTH-bit words on a valid/ready
// handshake and emits them MSB first, one bit per clock. A one-entry holding
// register lets a second word wait while the current word shifts out, so
// back-to-back words stream with no gap between them.
//
// Ports:
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-high; clears all state immediately
//   word_in     : parallel word, sampled only on an accepting edge
//   word_valid  : word_in is valid
//   word_ready  : block can accept a word (holding register empty)
//   data_out    : current serial bit, 0 when bit_valid is low
//   bit_valid   : data_out carries a real bit this cycle
//   last_bit    : data_out carries the LSB of a word
//   busy        : shifter active or holding register full
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   shift_q,     shift_d;
  logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [WIDTH-1:0]   hold_q,      hold_d;
  logic               hold_full_q, hold_full_d;

  logic accept;
  logic at_last;

  // Ready depends only on the holding register, so there is no
  // combinational path from word_valid to word_ready.
  assign accept  = word_valid && !hold_full_q;
  assign at_last = (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = word_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (!at_last) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = word_in;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // Held word follows the current LSB with no bubble.
          shift_d     = hold_q;
          bit_cnt_d   = '0;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // Word arriving during the LSB cycle bypasses the holding register.
          shift_d   = word_in;
          bit_cnt_d = '0;
        end else begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign word_ready = !hold_full_q;
  assign bit_valid  = (state_q == SHIFT);
  assign data_out   = (state_q == SHIFT) && shift_q[WIDTH-1];
  assign last_bit   = (state_q == SHIFT) && at_last;
  assign busy       = (state_q == SHIFT) || hold_full_q;

endmodule
